// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register: N fields of W bits behind a valid/ready handshake with a 2-entry skid buffer.
// Optional statistics counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_buf #(
   parameter int FIELD_W    = 32,
   parameter int NUM_FIELDS = 3,
   parameter int DATA_W     = FIELD_W * NUM_FIELDS
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [15:0]       bubble_cnt,
   output logic [15:0]       stall_cnt
);

   // State encoding equals the number of held entries, so occupancy is the state itself.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_head;
   logic [DATA_W-1:0] r_skid;
   logic              r_in_ready;
   logic              r_out_valid;

   logic              w_push;
   logic              w_pop;

   assign w_push = in_valid & r_in_ready;
   assign w_pop  = r_out_valid & out_ready;

   // NOTE: non-blocking assignments, so every branch below sees the pre-edge register values.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         // NOTE: the two data registers are cleared too, because out_data must read as a NOP bubble.
         r_state     <= ST_EMPTY;
         r_head      <= '0;
         r_skid      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else if (Flush) begin
         r_state     <= ST_EMPTY;
         r_head      <= '0;
         r_skid      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_push) begin
                  r_state     <= ST_ONE;
                  r_head      <= in_data;
                  r_out_valid <= 1'b1;
               end
            end
            ST_ONE: begin
               if (w_push && w_pop) begin
                  r_head <= in_data;
               end else if (w_push) begin
                  r_state    <= ST_TWO;
                  r_skid     <= in_data;
                  r_in_ready <= 1'b0;
               end else if (w_pop) begin
                  r_state     <= ST_EMPTY;
                  r_head      <= '0;
                  r_out_valid <= 1'b0;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so only a pop can happen.
               if (w_pop) begin
                  r_state    <= ST_ONE;
                  r_head     <= r_skid;
                  r_skid     <= '0;
                  r_in_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_EMPTY;
               r_head      <= '0;
               r_skid      <= '0;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_valid ? r_head : '0;
   assign occupancy = r_state;

`ifdef PIPE_STAGE_STATS_EN
   logic [15:0] r_bubble_cnt;
   logic [15:0] r_stall_cnt;

   // Saturating counters; Flush clears them and suppresses the bubble count on that cycle.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_bubble_cnt <= '0;
         r_stall_cnt  <= '0;
      end else if (Flush) begin
         r_bubble_cnt <= '0;
         r_stall_cnt  <= '0;
      end else begin
         if (!r_out_valid && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
         end
         if (in_valid && !r_in_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

   assign bubble_cnt = r_bubble_cnt;
   assign stall_cnt  = r_stall_cnt;
`else
   assign bubble_cnt = '0;
   assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed table, hand sequences and random traffic
// compared against a queue-based model of the stage.
module tb_pipe_stage_buf;

   localparam int FW = 32;
   localparam int NF = 3;
   localparam int DW = FW * NF;

   localparam logic [DW-1:0] WA = {3{32'h1111_1111}};
   localparam logic [DW-1:0] WB = {3{32'h2222_2222}};
   localparam logic [DW-1:0] WC = {3{32'h3333_3333}};
   localparam logic [DW-1:0] WD = {3{32'h4444_4444}};
   localparam logic [DW-1:0] WE = {3{32'h5555_5555}};
   localparam logic [DW-1:0] WF = {3{32'h6666_6666}};
   localparam logic [DW-1:0] WG = {3{32'h7777_7777}};
   localparam logic [DW-1:0] WH = {3{32'h8888_8888}};
   localparam logic [DW-1:0] W0 = {32'h4, 32'h2002_0005, 32'h0};
   localparam logic [39:0]   D5 = 40'h11_A5_33_44_55;

`ifdef PIPE_STAGE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;
   logic [15:0]   bubble_cnt;
   logic [15:0]   stall_cnt;

   logic          flush_5;
   logic          in_valid_5;
   logic          in_ready_5;
   logic [39:0]   in_data_5;
   logic          out_valid_5;
   logic          out_ready_5;
   logic [39:0]   out_data_5;
   logic [1:0]    occupancy_5;
   logic [15:0]   bubble_cnt_5;
   logic [15:0]   stall_cnt_5;

   always #5 Clk = ~Clk;

   pipe_stage_buf #(.FIELD_W(FW), .NUM_FIELDS(NF)) dut (
      .Clk(Clk), .Reset(Reset), .Flush(Flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
   );

   pipe_stage_buf #(.FIELD_W(8), .NUM_FIELDS(5)) dut5 (
      .Clk(Clk), .Reset(Reset), .Flush(flush_5),
      .in_valid(in_valid_5), .in_ready(in_ready_5), .in_data(in_data_5),
      .out_valid(out_valid_5), .out_ready(out_ready_5), .out_data(out_data_5),
      .occupancy(occupancy_5), .bubble_cnt(bubble_cnt_5), .stall_cnt(stall_cnt_5)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a FIFO of at most two words plus the two statistics counters.
   logic [DW-1:0] mq[$];
   int            m_bubble;
   int            m_stall;

   task automatic model_edge();
      bit push;
      bit pop;
      push = in_valid && (mq.size() < 2);
      pop  = (mq.size() > 0) && out_ready;
      if (Flush) begin
         mq.delete();
         m_bubble = 0;
         m_stall  = 0;
      end else begin
         if (mq.size() == 0 && m_bubble < 16'hFFFF) m_bubble++;
         if (in_valid && mq.size() == 2 && m_stall < 16'hFFFF) m_stall++;
         if (pop) mq.delete(0);
         if (push) mq.push_back(in_data);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_bubble = 0;
      m_stall  = 0;
   endtask

   task automatic compare_model(input string tag);
      logic [DW-1:0] exp_data;
      exp_data = (mq.size() > 0) ? mq[0] : '0;
      check({tag, ".out_valid"}, out_valid, mq.size() > 0);
      check({tag, ".out_data"},  out_data,  exp_data);
      check({tag, ".in_ready"},  in_ready,  mq.size() < 2);
      check({tag, ".occupancy"}, occupancy, mq.size());
      check({tag, ".bubble_cnt"}, bubble_cnt, STATS ? m_bubble : 0);
      check({tag, ".stall_cnt"},  stall_cnt,  STATS ? m_stall : 0);
   endtask

   task automatic step(input string tag, input bit fl, input bit iv,
                       input logic [DW-1:0] d, input bit ordy);
      Flush     = fl;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      @(posedge Clk);
      model_edge();
      #1;
      compare_model(tag);
   endtask

   typedef struct {
      bit            fl;
      bit            iv;
      logic [DW-1:0] d;
      bit            ordy;
      bit            e_valid;
      logic [DW-1:0] e_data;
      bit            e_ready;
      logic [1:0]    e_occ;
   } vec_t;

   vec_t tbl[15];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0]  = '{1'b0, 1'b1, WA, 1'b0, 1'b1, WA, 1'b1, 2'd1};
      tbl[1]  = '{1'b0, 1'b1, WB, 1'b0, 1'b1, WA, 1'b0, 2'd2};
      tbl[2]  = '{1'b0, 1'b1, WC, 1'b0, 1'b1, WA, 1'b0, 2'd2};
      tbl[3]  = '{1'b0, 1'b0, WC, 1'b1, 1'b1, WB, 1'b1, 2'd1};
      tbl[4]  = '{1'b0, 1'b0, WC, 1'b1, 1'b0, '0, 1'b1, 2'd0};
      tbl[5]  = '{1'b0, 1'b1, WA, 1'b0, 1'b1, WA, 1'b1, 2'd1};
      tbl[6]  = '{1'b0, 1'b1, WB, 1'b0, 1'b1, WA, 1'b0, 2'd2};
      tbl[7]  = '{1'b1, 1'b1, WC, 1'b0, 1'b0, '0, 1'b1, 2'd0};
      tbl[8]  = '{1'b0, 1'b1, WD, 1'b1, 1'b1, WD, 1'b1, 2'd1};
      tbl[9]  = '{1'b0, 1'b0, WD, 1'b1, 1'b0, '0, 1'b1, 2'd0};
      tbl[10] = '{1'b0, 1'b1, WE, 1'b1, 1'b1, WE, 1'b1, 2'd1};
      tbl[11] = '{1'b0, 1'b1, WF, 1'b1, 1'b1, WF, 1'b1, 2'd1};
      tbl[12] = '{1'b1, 1'b1, WG, 1'b1, 1'b0, '0, 1'b1, 2'd0};
      tbl[13] = '{1'b1, 1'b1, WG, 1'b0, 1'b0, '0, 1'b1, 2'd0};
      tbl[14] = '{1'b0, 1'b1, WH, 1'b0, 1'b1, WH, 1'b1, 2'd1};

      Reset       = 1'b1;
      Flush       = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      out_ready   = 1'b0;
      flush_5     = 1'b0;
      in_valid_5  = 1'b0;
      in_data_5   = D5;
      out_ready_5 = 1'b0;
      model_reset();
      #3;
      check("reset.out_valid", out_valid, 1'b0);
      check("reset.out_data", out_data, '0);
      check("reset.in_ready", in_ready, 1'b1);
      check("reset.occupancy", occupancy, 2'd0);
      check("reset.bubble_cnt", bubble_cnt, 16'd0);
      check("reset.stall_cnt", stall_cnt, 16'd0);
      @(negedge Clk);
      Reset = 1'b0;

      // Idle after reset: ten bubble cycles.
      for (int i = 0; i < 10; i++) step($sformatf("idle%0d", i), 1'b0, 1'b0, '0, 1'b0);
      check("idle.bubble_cnt10", bubble_cnt, STATS ? 16'd10 : 16'd0);

      // First word, then eight streamed words with out_ready held high.
      step("first", 1'b0, 1'b1, W0, 1'b1);
      check("first.out_data", out_data, W0);
      check("first.out_valid", out_valid, 1'b1);
      check("first.occupancy", occupancy, 2'd1);
      for (int i = 0; i < 8; i++) begin
         logic [DW-1:0] w;
         w = {32'h100 + i, 32'hA000_0000 + i, 32'h200 + i};
         step($sformatf("stream%0d", i), 1'b0, 1'b1, w, 1'b1);
         check($sformatf("stream%0d.word", i), out_data, w);
      end
      step("drain", 1'b0, 1'b0, '0, 1'b1);
      check("drain.out_valid", out_valid, 1'b0);

      // Directed vectors with hand-computed expectations.
      for (int i = 0; i < 15; i++) begin
         string t;
         t = $sformatf("tbl%0d", i);
         step(t, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
         check({t, ".v"}, out_valid, tbl[i].e_valid);
         check({t, ".d"}, out_data,  tbl[i].e_data);
         check({t, ".r"}, in_ready,  tbl[i].e_ready);
         check({t, ".o"}, occupancy, tbl[i].e_occ);
      end

      // Fill to TWO and hold with in_valid high for four cycles.
      step("st_flush", 1'b1, 1'b0, '0, 1'b0);
      step("st_a", 1'b0, 1'b1, WA, 1'b0);
      step("st_b", 1'b0, 1'b1, WB, 1'b0);
      for (int i = 0; i < 4; i++) step($sformatf("st_hold%0d", i), 1'b0, 1'b1, WC, 1'b0);
      check("stall.stall_cnt4", stall_cnt, STATS ? 16'd4 : 16'd0);
      check("stall.occupancy", occupancy, 2'd2);
      step("st_clear", 1'b1, 1'b1, WC, 1'b0);
      check("stall.clear_bubble", bubble_cnt, 16'd0);
      check("stall.clear_stall", stall_cnt, 16'd0);

      // Async reset pulsed between edges while traffic is flowing.
      step("ar0", 1'b0, 1'b1, WD, 1'b0);
      step("ar1", 1'b0, 1'b1, WE, 1'b0);
      #2;
      Reset = 1'b1;
      #1;
      check("async.out_valid", out_valid, 1'b0);
      check("async.out_data", out_data, '0);
      check("async.in_ready", in_ready, 1'b1);
      check("async.occupancy", occupancy, 2'd0);
      model_reset();
      @(negedge Clk);
      Reset = 1'b0;
      step("ar_after", 1'b0, 1'b1, WF, 1'b1);
      check("async.after_data", out_data, WF);

      // Five 8-bit fields: field 3 lands on bits [31:24].
      in_valid_5 = 1'b1;
      step("f5", 1'b0, 1'b0, '0, 1'b1);
      in_valid_5 = 1'b0;
      check("f5.out_valid", out_valid_5, 1'b1);
      check("f5.field3", out_data_5[31:24], 8'hA5);
      check("f5.all", out_data_5, D5);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step($sformatf("rnd%0d", i),
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 3) != 0),
              {$urandom(), $urandom(), $urandom()},
              ($urandom_range(0, 1) == 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline-stage register for the MIPS pipeline. It generalises the fixed three-word IF/ID latch to N fields of W bits.
- Replaces the write-enable stall with a valid/ready handshake. A 2-entry skid buffer decouples upstream ready from downstream ready.
- Synchronous flush turns the stage into a bubble. Output data is all-zero (NOP) whenever the stage holds no valid entry.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- FIELD_W, 32, width of each field in bits.
- NUM_FIELDS, 3, number of fields carried (e.g. PC+4, instruction, PC).
- DATA_W, FIELD_W*NUM_FIELDS, derived; do not override.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Flush  in  1  synchronous flush; discards all held entries.
- in_valid  in  1  upstream presents a word.
- in_ready  out  1  stage can accept a word this cycle.
- in_data  in  DATA_W  upstream fields; field k occupies bits [k*FIELD_W +: FIELD_W].
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head this cycle.
- out_data  out  DATA_W  head entry; 0 when out_valid=0.
- occupancy  out  2  entries held: 0, 1 or 2.
- bubble_cnt  out  16  see Optional Feature.
- stall_cnt  out  16  see Optional Feature.

Behaviour:
- Reset (async, immediate on assertion): state EMPTY; both entries cleared to 0. Outputs: out_valid=0, out_data=0, in_ready=1, occupancy=0, counters=0.
- Storage: head register H and skid register S, FIFO order (H older).
- Transfers:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Both are evaluated on the same rising edge.
- State EMPTY (occ 0):
  - push -> ONE, H<=in_data.
  - No push -> stay.
- State ONE (occ 1):
  - push & pop -> ONE, H<=in_data.
  - push only -> TWO, S<=in_data.
  - pop only -> EMPTY, H<=0.
  - Neither -> hold.
- State TWO (occ 2):
  - in_ready=0, so no push.
  - pop -> ONE, H<=S, S<=0.
  - No pop -> hold.
- in_ready is registered: 1 in EMPTY and ONE, 0 in TWO. It never depends combinationally on out_ready.
- out_valid=1 in ONE and TWO. out_data=H when valid, else 0. occupancy reflects state.
- Latency: one cycle from push to out_valid when empty. Full throughput (one word/cycle) with out_ready held high.
- Flush, sampled on a rising edge:
  - Next state EMPTY, H=S=0.
  - A same-cycle push is discarded. A same-cycle pop still counts downstream (data consumed), but the state result is EMPTY.
  - Flush has priority over every transfer.
- Flush and in_valid held high: the word after the flush edge is accepted normally (in_ready=1).
- Data is never reordered, duplicated or dropped except by Flush.
- No combinational path from in_data to out_data.
- Reset asserted mid-transfer: contents lost, outputs go to reset values immediately. Deassertion is synchronised externally.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined:
  - bubble_cnt increments on each cycle with out_valid=0 and Flush=0.
  - stall_cnt increments on each cycle with in_valid=1 and in_ready=0.
  - Both are 16-bit, saturate at 0xFFFF, and clear on Reset and on Flush.
- Undefined: both ports are tied to constant 0 and no counter logic is synthesised. Handshake behaviour is identical either way.

Test Plan:
- Reset, in_valid=1, in_data={32'h4,32'h2002_0005,32'h0}, out_ready=1 -> next edge out_valid=1, out_data matches, occupancy=1. Streaming 8 words one per cycle gives them in order with no gaps.
- Fill then block: out_ready=0, push A=0x11..., B=0x22... -> occupancy=2, in_ready=0 after the 2nd edge. Raise out_ready -> A then B on consecutive cycles, in_ready returns to 1 after the first pop.
- Flush in TWO with in_valid=1 carrying C -> next edge occupancy=0, out_valid=0, out_data=0, C not delivered. The following word D is delivered one cycle later.
- Async Reset pulsed mid-stream between clock edges -> out_valid=0, out_data=0 and in_ready=1 immediately, before the next edge.
- NUM_FIELDS=5, FIELD_W=8: field 3 input 8'hA5 -> appears at out_data[31:24]; all other bits match input.
- With PIPE_STAGE_STATS_EN: idle 10 cycles after reset -> bubble_cnt=10. Hold TWO with in_valid=1 for 4 cycles -> stall_cnt=4. Flush -> both 0. Without the macro both read 0 throughout.
